// File: rtl/pc_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pipe_pkg
// Description : Shared definitions for the PC pipe register. Holds the
//               all-ones preset (exception) vector and the encoding of the
//               fixed-priority next-PC select.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pipe_pkg;

    // Widest PC supported. The preset vector is sliced down to the PC width.
    localparam int unsigned PC_MAX_BITS = 64;
    localparam logic [PC_MAX_BITS-1:0] PC_ALL_ONES = '1;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_PRE   = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_HOLD  = 3'd2,
        SEL_PRED  = 3'd3,
        SEL_SEQ   = 3'd4
    } pc_sel_e;

endpackage : pc_pipe_pkg
`default_nettype wire

// File: rtl/pc_shadow_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_shadow_stage
// Description : One entry of the in-flight PC shadow chain (PC + valid bit).
//               Clear drops the valid bit but keeps the stored PC. Shift
//               loads the entry from its upstream neighbour. With neither
//               control set, the entry holds.
// Ports       : Clock, Reset (async, active-low)
//               Shift, Clear         - entry controls
//               InPc, InValid        - upstream entry
//               OutPc, OutValid      - this entry
// Revision    : 1.0 - initial release
// ============================================================================
module pc_shadow_stage #(
    parameter int unsigned NrOfBits = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Shift,
    input  logic                Clear,
    input  logic [NrOfBits-1:0] InPc,
    input  logic                InValid,
    output logic [NrOfBits-1:0] OutPc,
    output logic                OutValid
);

    logic [NrOfBits-1:0] r_pc;
    logic                r_valid;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (Clear) begin
            r_valid <= 1'b0;
        end else if (Shift) begin
            r_pc    <= InPc;
            r_valid <= InValid;
        end
    end

    assign OutPc    = r_pc;
    assign OutValid = r_valid;

endmodule : pc_shadow_stage
`default_nettype wire

// File: rtl/pc_pipe_register.sv
`default_nettype none
// ============================================================================
// Module      : pc_pipe_register
// Description : Fetch program-counter register with fixed-priority next-PC
//               select (preset, redirect, stall, predicted target,
//               sequential) and a Depth-entry shadow chain of in-flight PCs.
// Ports       : Clock, Reset (async, active-low)
//               ClockEnable, Tick    - state updates only when both are set
//               Pre                  - load all-ones exception vector
//               Stall                - hold PC and chain
//               Redirect, RedirectPc - flush to a new PC
//               PredTaken, PredTarget- BTB prediction
//               Pc                   - current fetch PC
//               StagePc, StageValid  - shadow chain, stage 0 youngest
//               RedirectCount        - saturating flush counter
// Revision    : 1.0 - initial release
// ============================================================================
module pc_pipe_register
    import pc_pipe_pkg::*;
#(
    parameter int unsigned     NrOfBits    = 32,
    parameter int unsigned     Depth       = 4,
    parameter int unsigned     IncBytes    = 4,
    parameter longint unsigned ResetVector = 0,
    parameter int unsigned     CountBits   = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      ClockEnable,
    input  logic                      Tick,
    input  logic                      Pre,
    input  logic                      Stall,
    input  logic                      Redirect,
    input  logic [NrOfBits-1:0]       RedirectPc,
    input  logic                      PredTaken,
    input  logic [NrOfBits-1:0]       PredTarget,
    output logic [NrOfBits-1:0]       Pc,
    output logic [Depth*NrOfBits-1:0] StagePc,
    output logic [Depth-1:0]          StageValid,
    output logic [CountBits-1:0]      RedirectCount
);

    localparam logic [NrOfBits-1:0] c_reset_pc = NrOfBits'(ResetVector);
    localparam logic [NrOfBits-1:0] c_inc      = NrOfBits'(IncBytes);
    localparam logic [NrOfBits-1:0] c_preset   = PC_ALL_ONES[NrOfBits-1:0];

    logic [NrOfBits-1:0]  r_pc;
    logic [CountBits-1:0] r_count;

    logic                 w_en;
    pc_sel_e              w_sel;
    logic [NrOfBits-1:0]  w_pc_next;
    logic                 w_shift;
    logic                 w_clear;

    // Element 0 is the chain input (the current PC, always valid);
    // element i+1 is the output of shadow stage i.
    logic [Depth:0][NrOfBits-1:0] w_chain_pc;
    logic [Depth:0]               w_chain_valid;

    assign w_en = ClockEnable & Tick;

    always_comb begin
        w_sel = SEL_SEQ;
        if (Pre)
            w_sel = SEL_PRE;
        else if (Redirect)
            w_sel = SEL_REDIR;
        else if (Stall)
            w_sel = SEL_HOLD;
        else if (PredTaken)
            w_sel = SEL_PRED;
    end

    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            SEL_PRE:   w_pc_next = c_preset;
            SEL_REDIR: w_pc_next = RedirectPc;
            SEL_PRED:  w_pc_next = PredTarget;
            SEL_SEQ:   w_pc_next = r_pc + c_inc;  // wraps modulo 2^NrOfBits
            default:   w_pc_next = r_pc;
        endcase
    end

    // The chain advances exactly when a new PC is fetched; preset and
    // redirect invalidate every in-flight entry but keep their PCs.
    assign w_shift = w_en & ((w_sel == SEL_PRED) | (w_sel == SEL_SEQ));
    assign w_clear = w_en & ((w_sel == SEL_PRE) | (w_sel == SEL_REDIR));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_pc    <= c_reset_pc;
            r_count <= '0;
        end else if (w_en) begin
            r_pc <= w_pc_next;
            if ((w_sel == SEL_REDIR) && (r_count != {CountBits{1'b1}}))
                r_count <= r_count + CountBits'(1);
        end
    end

    assign w_chain_pc[0]    = r_pc;
    assign w_chain_valid[0] = 1'b1;

    generate
        for (genvar i = 0; i < int'(Depth); i++) begin : g_stage
            pc_shadow_stage #(
                .NrOfBits (NrOfBits)
            ) u_stage (
                .Clock    (Clock),
                .Reset    (Reset),
                .Shift    (w_shift),
                .Clear    (w_clear),
                .InPc     (w_chain_pc[i]),
                .InValid  (w_chain_valid[i]),
                .OutPc    (w_chain_pc[i+1]),
                .OutValid (w_chain_valid[i+1])
            );
        end
    endgenerate

    assign Pc            = r_pc;
    assign StagePc       = w_chain_pc[Depth:1];
    assign StageValid    = w_chain_valid[Depth:1];
    assign RedirectCount = r_count;

endmodule : pc_pipe_register
`default_nettype wire

// File: tb/tb_pc_pipe_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_pipe_register
// Description : Scoreboard testbench for pc_pipe_register. A behavioural
//               model predicts the outputs after every edge; a monitor pops
//               the predictions and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_pipe_register;

    localparam int unsigned NB = 32;
    localparam int unsigned DP = 4;
    localparam int unsigned CB = 2;
    localparam logic [31:0]  RV = 32'h0000_0100;

    logic              Clock;
    logic              Reset;
    logic              ClockEnable;
    logic              Tick;
    logic              Pre;
    logic              Stall;
    logic              Redirect;
    logic [NB-1:0]     RedirectPc;
    logic              PredTaken;
    logic [NB-1:0]     PredTarget;
    logic [NB-1:0]     Pc;
    logic [DP*NB-1:0]  StagePc;
    logic [DP-1:0]     StageValid;
    logic [CB-1:0]     RedirectCount;

    pc_pipe_register #(
        .NrOfBits    (NB),
        .Depth       (DP),
        .IncBytes    (4),
        .ResetVector (64'(RV)),
        .CountBits   (CB)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .ClockEnable   (ClockEnable),
        .Tick          (Tick),
        .Pre           (Pre),
        .Stall         (Stall),
        .Redirect      (Redirect),
        .RedirectPc    (RedirectPc),
        .PredTaken     (PredTaken),
        .PredTarget    (PredTarget),
        .Pc            (Pc),
        .StagePc       (StagePc),
        .StageValid    (StageValid),
        .RedirectCount (RedirectCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        bit          v;
    } sh_t;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] spc;
        logic [3:0]   sval;
        logic [1:0]   cnt;
    } exp_t;

    logic [31:0] m_pc;
    sh_t         m_sh[$];   // front = youngest in-flight instruction
    int          m_cnt;
    exp_t        sb[$];

    int n_pass  = 0;
    int n_total = 0;

    function automatic void model_reset();
        m_pc  = RV;
        m_cnt = 0;
        m_sh.delete();
        for (int i = 0; i < 4; i++) m_sh.push_back('{pc: 32'h0, v: 1'b0});
    endfunction

    function automatic void model_edge(bit en, bit pre, bit stl, bit rd,
                                       logic [31:0] rpc, bit pt, logic [31:0] tgt);
        sh_t s;
        if (!en) return;
        if (pre || rd) begin
            for (int i = 0; i < 4; i++) m_sh[i].v = 1'b0;
            if (pre) begin
                m_pc = 32'hFFFF_FFFF;
            end else begin
                m_pc = rpc;
                if (m_cnt < 3) m_cnt++;
            end
        end else if (!stl) begin
            s.pc = m_pc;
            s.v  = 1'b1;
            m_sh.push_front(s);
            void'(m_sh.pop_back());
            m_pc = pt ? tgt : m_pc + 32'd4;
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.pc = m_pc;
        for (int i = 0; i < 4; i++) begin
            e.spc[i*32 +: 32] = m_sh[i].pc;
            e.sval[i]         = m_sh[i].v;
        end
        e.cnt = m_cnt[1:0];
        return e;
    endfunction

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endfunction

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge Clock) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_pc",    128'(Pc),            128'(mon_e.pc));
            chk("sb_spc",   128'(StagePc),       mon_e.spc);
            chk("sb_sval",  128'(StageValid),    128'(mon_e.sval));
            chk("sb_count", 128'(RedirectCount), 128'(mon_e.cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit ce, input bit tk, input bit pre, input bit stl,
                        input bit rd, input logic [31:0] rpc,
                        input bit pt, input logic [31:0] tgt);
        @(negedge Clock);
        ClockEnable = ce;
        Tick        = tk;
        Pre         = pre;
        Stall       = stl;
        Redirect    = rd;
        RedirectPc  = rpc;
        PredTaken   = pt;
        PredTarget  = tgt;
        @(posedge Clock);
        #1;
        model_edge(ce & tk, pre, stl, rd, rpc, pt, tgt);
        sb.push_back(snap());
    endtask

    task automatic advance();
        step(1, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        model_reset();
        sb.push_back(snap());
        #1;
        chk("reset_immediate_pc",    128'(Pc),         128'(RV));
        chk("reset_immediate_valid", 128'(StageValid), 128'(0));
        @(posedge Clock);
        #2;
        Reset = 1'b1;
    endtask

    initial begin
        Reset       = 1'b0;
        ClockEnable = 1'b0;
        Tick        = 1'b0;
        Pre         = 1'b0;
        Stall       = 1'b0;
        Redirect    = 1'b0;
        RedirectPc  = '0;
        PredTaken   = 1'b0;
        PredTarget  = '0;
        model_reset();
        sb.push_back(snap());
        repeat (2) @(posedge Clock);
        #2;
        Reset = 1'b1;

        // Three sequential fetches from the reset vector.
        repeat (3) advance();
        chk("seq3_pc",   128'(Pc),              128'(32'h10C));
        chk("seq3_sval", 128'(StageValid),      128'(4'b0111));
        chk("seq3_s0",   128'(StagePc[31:0]),   128'(32'h108));
        chk("seq3_s1",   128'(StagePc[63:32]),  128'(32'h104));
        chk("seq3_s2",   128'(StagePc[95:64]),  128'(32'h100));

        // Mid-run reset, then resume from the reset vector.
        pulse_reset();
        advance();
        chk("resume_pc", 128'(Pc),            128'(32'h104));
        chk("resume_s0", 128'(StagePc[31:0]), 128'(32'h100));

        // Predicted-taken branch at 0x104.
        step(1, 1, 0, 0, 0, 32'h0, 1, 32'h400);
        chk("pred_pc", 128'(Pc),            128'(32'h400));
        chk("pred_s0", 128'(StagePc[31:0]), 128'(32'h104));

        // Two stall cycles, the second one with a redirect.
        step(1, 1, 0, 1, 0, 32'h0,   1, 32'h999);
        chk("stall_pc", 128'(Pc), 128'(32'h400));
        step(1, 1, 0, 1, 1, 32'h800, 1, 32'h999);
        chk("redir_pc",   128'(Pc),            128'(32'h800));
        chk("redir_sval", 128'(StageValid),    128'(0));
        chk("redir_cnt",  128'(RedirectCount), 128'(1));

        // Preset beats redirect; next fetch wraps past all-ones.
        step(1, 1, 1, 0, 1, 32'h1234, 0, 32'h0);
        chk("pre_pc",  128'(Pc),            128'(32'hFFFF_FFFF));
        chk("pre_cnt", 128'(RedirectCount), 128'(1));
        advance();
        chk("wrap_pc", 128'(Pc),            128'(32'h3));
        chk("wrap_s0", 128'(StagePc[31:0]), 128'(32'hFFFF_FFFF));

        // Disabled cycles ignore everything.
        repeat (5) step(1, 0, 0, 0, 1, 32'hABC, 0, 32'h0);
        step(0, 1, 1, 0, 1, 32'hABC, 0, 32'h0);
        chk("gated_pc",  128'(Pc),            128'(32'h3));
        chk("gated_cnt", 128'(RedirectCount), 128'(1));

        // Counter saturates at all-ones.
        for (int i = 1; i <= 5; i++) step(1, 1, 0, 0, 1, 32'(i * 16), 0, 32'h0);
        chk("sat_cnt", 128'(RedirectCount), 128'(3));
        chk("sat_pc",  128'(Pc),            128'(32'h50));

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 96) pulse_reset();
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom,
                 ($urandom_range(0, 2) == 0),
                 $urandom);
        end

        @(negedge Clock);
        #1;
        chk("scoreboard_drain", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_pipe_register
`default_nettype wire

// File: doc/pc_pipe_register.md
# pc_pipe_register

Parametrised program-counter register for the redirection pipeline, successor to the single-word PC flip-flop. It holds the fetch PC and computes the next PC with fixed priority: preset, redirect, stall, BTB-predicted target, sequential increment. It also keeps a `Depth`-entry shadow chain of the PCs and valid bits of in-flight instructions, which later stages use for mispredict recovery. It sits between the BTB/next-PC logic and instruction memory.

## Interface
Parameters:
- `NrOfBits`, 32, PC width.
- `Depth`, 4, number of shadow stages (≥1).
- `IncBytes`, 4, sequential increment.
- `ResetVector`, 0, PC value after reset.
- `CountBits`, 8, width of the redirect counter.

Ports:
- `Clock` in 1: the single clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-low.
- `ClockEnable` in 1: global enable.
- `Tick` in 1: clock-gating tick. Nothing updates unless `ClockEnable&Tick`.
- `Pre` in 1: synchronous preset; loads the all-ones exception vector.
- `Stall` in 1: hold PC and shadow chain.
- `Redirect` in 1: mispredict/jump flush.
- `RedirectPc` in NrOfBits: flush target.
- `PredTaken` in 1: BTB hit and predicted taken.
- `PredTarget` in NrOfBits: BTB target.
- `Pc` out NrOfBits: current fetch PC.
- `StagePc` out Depth*NrOfBits: shadow PCs; stage i occupies bits [i*NrOfBits +: NrOfBits], stage 0 is youngest.
- `StageValid` out Depth: per-stage valid.
- `RedirectCount` out CountBits: saturating flush counter.

## Operation
- `en = ClockEnable & Tick`. When `en` is 0, all state holds, including against `Pre` and `Redirect`.
- Priority when `en` is 1:
  - Pre: `Pc <= {NrOfBits{1}}`; all `StageValid <= 0`; `StagePc` unchanged; counter unchanged.
  - Redirect: `Pc <= RedirectPc`; all `StageValid <= 0`; `StagePc` unchanged; `RedirectCount` increments, saturating at all-ones. Redirect overrides Stall.
  - Stall: everything holds.
  - Advance, PredTaken=1: `Pc <= PredTarget`.
  - Advance, PredTaken=0: `Pc <= Pc + IncBytes`, modulo 2^NrOfBits (wraps, no carry out).
- On every advance the shadow chain shifts:
  - `StagePc[0] <= Pc` and `StageValid[0] <= 1`.
  - `StagePc[i] <= StagePc[i-1]` and `StageValid[i] <= StageValid[i-1]`.
  - Stage Depth-1 is discarded.
- `PredTaken` is ignored during Pre, Redirect and Stall cycles.
- `RedirectCount` is never cleared except by `Reset`.

## Timing
- Reset (`Reset`=0), asynchronous and immediate:
  - `Pc = ResetVector`.
  - `StagePc` = all 0.
  - `StageValid` = 0.
  - `RedirectCount` = 0.
- Reset deassertion is synchronised externally; the block treats it as clean.
- Latency: all outputs are registered. An input sampled at edge N is visible after edge N; there is no combinational input-to-output path.
- After reset, the first advancing edge puts `ResetVector` into stage 0 and `ResetVector+IncBytes` into `Pc`.
- Reset asserted mid-operation overrides every pending Pre, Redirect or advance in the same cycle.
- Redirect together with Stall: the redirect is taken, and the chain is cleared rather than held.
- Redirect in consecutive cycles: each one loads `Pc` and increments the counter.
- Once `RedirectCount` is at all-ones, further redirects leave it at all-ones.
- Pc wrap: with `Pc` = all-ones-minus-3 and `IncBytes`=4, the next `Pc` is 0.

## Structure
- A shared package `pc_pipe_pkg` holds:
  - `PC_ALL_ONES` preset constant.
  - the priority-select encoding enum {SEL_PRE, SEL_REDIR, SEL_HOLD, SEL_PRED, SEL_SEQ}.
- Combinational next-PC select in the top module.
- One sub-module, `pc_shadow_stage`: a single shadow entry (PC plus valid) with shift, hold and clear controls. The top module instantiates `Depth` of them in a generate chain.

## Test plan
- Reset with `ResetVector`=0x100, then 3 advances, no prediction → `Pc`=0x10C; StagePc[0..2]=0x108, 0x104, 0x100; StageValid=0b0111.
- PredTaken=1, PredTarget=0x400, asserted for one advance at `Pc`=0x104 → `Pc`=0x400; StagePc[0]=0x104.
- Stall for 2 cycles with Redirect=1, RedirectPc=0x800 in the second → `Pc`=0x800; StageValid=0; RedirectCount=1.
- Pre=1 together with Redirect=1 → `Pc`=0xFFFFFFFF; RedirectCount unchanged. Next advance → `Pc`=0x3 (wrap), StagePc[0]=0xFFFFFFFF.
- `Tick`=0 with Redirect=1 for 5 cycles → no state change. With CountBits=2 and 5 enabled redirects → RedirectCount=3.
- `Reset` pulsed low between edges mid-run → outputs return to reset values immediately; the next advance resumes from `ResetVector`.
